tx_cell_queue: RTL and testbench
================================

TX_CELL_QUEUE -- requirements
Module: tx_cell_queue

Interface
REQ-001 Parameter Depth, default 4: cell slots in the queue; legal values 2, 4 or 8.
REQ-002 Parameter CellBytes, default 53: bytes per ATM cell; fixed at 53.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  forwarding stage presents a cell.
REQ-006 in_ready  output  1  queue can accept a cell this cycle.
REQ-007 in_cell  input  424  cell; byte 0 (first on the wire) is in_cell[423:416], byte 52 is in_cell[7:0].
REQ-008 tx_clav  input  1  PHY cell-available: PHY can take a full cell.
REQ-009 tx_enb_n  output  1  active-low byte-enable to PHY.
REQ-010 tx_soc  output  1  start-of-cell, high with byte 0 only.
REQ-011 tx_data  output  8  cell byte.
REQ-012 occupancy  output  4  cells stored, 0..Depth.
REQ-013 cells_sent  output  16  count of completed cells, saturating.

Function
REQ-014 Accept: a cell SHALL be written when in_valid && in_ready at a rising edge; in_ready SHALL equal (occupancy != Depth), combinational from registered count.
REQ-015 FIFO order: cells SHALL leave in acceptance order; write/read pointers wrap modulo Depth.
REQ-016 FSM states: IDLE, SEND; byte index register idx 0..52.
REQ-017 IDLE -> SEND at an edge when occupancy != 0 && tx_clav == 1; that edge SHALL register tx_enb_n=0, tx_soc=1, tx_data=byte 0, idx=0.
REQ-018 Latency: a cell accepted at edge k into an empty queue, with tx_clav high, SHALL drive byte 0 from edge k+1.
REQ-019 SEND: each edge with idx<52 SHALL increment idx and drive byte idx+1, tx_soc=0, tx_enb_n=0.
REQ-020 tx_clav SHALL be ignored after a cell starts; a cell is never paused or aborted.
REQ-021 At the edge leaving idx=52 the read pointer SHALL advance (pop), cells_sent SHALL increment unless already 16'hFFFF.
REQ-022 Back-to-back: at that edge, if occupancy >= 2 (count before pop) and tx_clav == 1, next cell's byte 0 SHALL be driven immediately (no idle cycle); otherwise go IDLE.
REQ-023 In IDLE, outputs SHALL be tx_enb_n=1, tx_soc=0, tx_data=8'h00.
REQ-024 Simultaneous push and pop at one edge: occupancy unchanged; push with a full queue cannot occur since in_ready=0.
REQ-025 The cell being sent SHALL stay in its slot until popped, so a full queue keeps in_ready low throughout its transmission.
REQ-026 All outputs except in_ready SHALL be registered.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, idx=0, pointers=0, occupancy=0, cells_sent=0, tx_enb_n=1, tx_soc=0, tx_data=8'h00; in_ready=1.
REQ-028 Reset mid-cell SHALL abandon the cell and discard all queued cells; no partial byte is driven after rst_n falls.
REQ-029 Deassertion SHALL take effect on the first rising edge with rst_n high; in_valid during reset is ignored.

Verification
REQ-030 Single cell: push cell bytes 0x00..0x34, tx_clav=1 -> soc at edge k+1 with data 0x00, 53 consecutive enabled bytes 0x00..0x34, then enb_n=1, cells_sent=1, occupancy=0.
REQ-031 Fill: push 5 cells with tx_clav=0, Depth=4 -> 4 accepted, in_ready=0 after the 4th, occupancy=4, no bytes driven.
REQ-032 Back-to-back: 3 cells queued, tx_clav=1 -> 159 contiguous enabled cycles, soc at offsets 0, 53, 106, in order.
REQ-033 Clav drop mid-cell: tx_clav goes 0 at byte 10 -> cell completes all 53 bytes, then IDLE until tx_clav=1.
REQ-034 Full with simultaneous ops: queue full, sending; push offered at pop edge -> rejected that edge, accepted next edge, occupancy back to 4.
REQ-035 Reset mid-cell at byte 20 with 2 cells queued -> enb_n=1 immediately, occupancy=0, cells_sent=0; fresh cell afterwards is sent intact.

Source files
------------

// File: rtl/tx_cell_queue.sv
// tx_cell_queue: Depth-slot ATM cell FIFO feeding a UTOPIA-style byte-wide PHY transmit port.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_valid_i      forwarding stage presents a cell on in_cell_i
//   in_ready_o      queue can accept a cell this cycle (combinational from the registered count)
//   in_cell_i       53-byte cell, byte 0 in the top byte
//   tx_clav_i       PHY can take a full cell
//   tx_enb_n_o      active-low byte enable to the PHY
//   tx_soc_o        start of cell, high with byte 0 only
//   tx_data_o       cell byte
//   occupancy_o     cells stored, including the one being sent
//   cells_sent_o    completed cells, saturating
module tx_cell_queue #(
  parameter int Depth     = 4,
  parameter int CellBytes = 53
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [8*CellBytes-1:0] in_cell_i,
  input  logic                   tx_clav_i,
  output logic                   tx_enb_n_o,
  output logic                   tx_soc_o,
  output logic [7:0]             tx_data_o,
  output logic [3:0]             occupancy_o,
  output logic [15:0]            cells_sent_o
);
  localparam int CW = 8 * CellBytes;
  localparam int AW = $clog2(Depth);
  localparam logic [5:0] LAST = 6'(CellBytes - 1);
  typedef enum logic {IDLE, SEND} state_e;
  logic [CW-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [3:0]    count_q, count_d;
  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic          enb_n_q, enb_n_d, soc_q, soc_d;
  logic [7:0]    data_q, data_d;
  logic [15:0]   sent_q;
  logic          push, pop, start;
  // Byte i sits at bit offset 8*(52-i): byte 0 is the first one on the wire.
  function automatic logic [7:0] cell_byte(input logic [CW-1:0] c, input logic [5:0] i);
    return c[{LAST - i, 3'b000} +: 8];
  endfunction
  assign in_ready_o = count_q != 4'(Depth);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = state_q == SEND && idx_q == LAST;
  assign start      = count_q != 4'd0 && tx_clav_i;
  assign rd_nxt     = rd_ptr_q + AW'(1);
  assign count_d    = count_q + 4'(push) - 4'(pop);
  // Each branch computes the registered byte-lane values for the next cycle.
  // On the final byte, the next cell may start back-to-back from the slot after
  // the one being popped, provided it was already queued and the PHY has room.
  always_comb begin
    state_d = state_q;
    idx_d   = 6'd0;
    enb_n_d = 1'b1;
    soc_d   = 1'b0;
    data_d  = 8'h00;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SEND;
        enb_n_d = 1'b0;
        soc_d   = 1'b1;
        data_d  = cell_byte(mem_q[rd_ptr_q], 6'd0);
      end
    end else if (!pop) begin
      idx_d   = idx_q + 6'd1;
      enb_n_d = 1'b0;
      data_d  = cell_byte(mem_q[rd_ptr_q], idx_q + 6'd1);
    end else if (count_q >= 4'd2 && tx_clav_i) begin
      enb_n_d = 1'b0;
      soc_d   = 1'b1;
      data_d  = cell_byte(mem_q[rd_nxt], 6'd0);
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_cell_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 6'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      sent_q   <= 16'd0;
      enb_n_q  <= 1'b1;
      soc_q    <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_nxt : rd_ptr_q;
      count_q  <= count_d;
      sent_q   <= (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
      enb_n_q  <= enb_n_d;
      soc_q    <= soc_d;
      data_q   <= data_d;
    end
  end
  assign tx_enb_n_o   = enb_n_q;
  assign tx_soc_o     = soc_q;
  assign tx_data_o    = data_q;
  assign occupancy_o  = count_q;
  assign cells_sent_o = sent_q;
endmodule

// File: tb/tb_tx_cell_queue.sv
// tb_tx_cell_queue: directed scoreboard bench for tx_cell_queue.
// Ports: none (top-level bench).
module tb_tx_cell_queue;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [423:0] in_cell = '0;
  logic         tx_clav = 1'b0;
  logic         tx_enb_n, tx_soc;
  logic [7:0]   tx_data;
  logic [3:0]   occupancy;
  logic [15:0]  cells_sent;
  int           n_assert = 0;
  int           n_fail = 0;
  logic [8:0]   sb [$];
  logic [8:0]   e;

  tx_cell_queue #(.Depth(4), .CellBytes(53)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_cell_i(in_cell),
    .tx_clav_i(tx_clav), .tx_enb_n_o(tx_enb_n), .tx_soc_o(tx_soc), .tx_data_o(tx_data),
    .occupancy_o(occupancy), .cells_sent_o(cells_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [423:0] mk(input logic [7:0] b);
    logic [423:0] c;
    for (int i = 0; i < 53; i++) c[423-8*i -: 8] = b + 8'(i);
    return c;
  endfunction

  task automatic sb_add(input logic [7:0] b);
    for (int i = 0; i < 53; i++) sb.push_back({i == 0, b + 8'(i)});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, output bit acc);
    in_valid = 1'b1;
    in_cell  = mk(b);
    acc      = in_ready;
    if (acc) sb_add(b);
    step(1);
    in_valid = 1'b0;
  endtask

  // Runs until the queue and scoreboard are empty and the lane is idle, then
  // checks byte count, contiguity and start-of-cell positions.
  task automatic drain(input string tag, input int exp_en, input int exp_soc, input int soc0);
    int en = 0, first = -1, last = -1, nsoc = 0, bad = 0;
    bit to = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if (!tx_enb_n) begin
        if (first < 0) first = t;
        last = t;
        en++;
        if (tx_soc) begin
          if (t - first != soc0 + nsoc * 53) bad++;
          nsoc++;
        end
      end else if (en > 0 && sb.size() == 0 && occupancy == 4'd0) begin
        to = 1'b0;
        break;
      end
      step(1);
    end
    chk({tag, "_timeout"}, 32'(to), 0);
    chk({tag, "_bytes"}, en, exp_en);
    chk({tag, "_contig"}, last - first + 1, exp_en);
    chk({tag, "_socs"}, nsoc, exp_soc);
    chk({tag, "_soc_pos"}, bad, 0);
  endtask

  // Byte-lane monitor: every enabled byte must be the next scoreboard entry,
  // and an idle lane must show soc=0, data=0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!tx_enb_n) begin
        if (sb.size() == 0) chk("spurious_byte", 32'(tx_enb_n), 1);
        else begin
          e = sb.pop_front();
          chk("byte_data", 32'(tx_data), 32'(e[7:0]));
          chk("byte_soc", 32'(tx_soc), 32'(e[8]));
        end
      end else begin
        chk("idle_soc", 32'(tx_soc), 0);
        chk("idle_data", 32'(tx_data), 0);
      end
    end
  end

  initial begin
    bit acc;
    int n;
    // Reset with in_valid asserted: must be ignored.
    in_valid = 1'b1;
    in_cell  = mk(8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_enb_n", 32'(tx_enb_n), 1);
    chk("rst_soc", 32'(tx_soc), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_sent", 32'(cells_sent), 0);
    chk("rst_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step(1);
    chk("rel_occ", 32'(occupancy), 0);
    // Single cell, bytes 0x00..0x34.
    tx_clav = 1'b1;
    push(8'h00, acc);
    chk("single_acc", 32'(acc), 1);
    chk("single_occ", 32'(occupancy), 1);
    chk("single_not_yet", 32'(tx_enb_n), 1);
    step(1);
    chk("single_lat_enb", 32'(tx_enb_n), 0);
    chk("single_lat_soc", 32'(tx_soc), 1);
    chk("single_lat_data", 32'(tx_data), 0);
    drain("single", 53, 1, 0);
    chk("single_sent", 32'(cells_sent), 1);
    chk("single_ready", 32'(in_ready), 1);
    // Fill with PHY unavailable: only Depth cells accepted.
    tx_clav = 1'b0;
    push(8'h10, acc); chk("fill_acc1", 32'(acc), 1);
    push(8'h20, acc); chk("fill_acc2", 32'(acc), 1);
    push(8'h30, acc); chk("fill_acc3", 32'(acc), 1);
    push(8'h40, acc); chk("fill_acc4", 32'(acc), 1);
    chk("fill_ready", 32'(in_ready), 0);
    push(8'h50, acc); chk("fill_acc5", 32'(acc), 0);
    chk("fill_occ", 32'(occupancy), 4);
    chk("fill_idle", 32'(tx_enb_n), 1);
    // Full while sending: push held from before the first byte is only taken after the pop edge.
    tx_clav  = 1'b1;
    in_valid = 1'b1;
    in_cell  = mk(8'h60);
    chk("full_ready_lo", 32'(in_ready), 0);
    n = 0;
    while (!in_ready && n < 200) begin
      step(1);
      n++;
    end
    chk("full_pop_wait", n, 54);
    chk("full_occ_pop", 32'(occupancy), 3);
    sb_add(8'h60);
    step(1);
    in_valid = 1'b0;
    chk("full_occ_refill", 32'(occupancy), 4);
    chk("full_ready_refill", 32'(in_ready), 0);
    drain("full_b2b", 211, 3, 52);
    chk("full_sent", 32'(cells_sent), 6);
    // Three cells back-to-back.
    tx_clav = 1'b0;
    push(8'hA0, acc);
    push(8'hB0, acc);
    push(8'hC0, acc);
    chk("b2b_occ", 32'(occupancy), 3);
    tx_clav = 1'b1;
    drain("b2b3", 159, 3, 0);
    chk("b2b_sent", 32'(cells_sent), 9);
    // PHY drops clav at byte 10: cell completes, next one waits.
    push(8'h80, acc);
    push(8'h90, acc);
    chk("clav_b_acc", 32'(acc), 1);
    step(10);
    chk("clav_byte10", 32'(tx_data), 32'h8A);
    tx_clav = 1'b0;
    n = 0;
    while (!tx_enb_n && n < 200) begin
      step(1);
      n++;
    end
    chk("clav_tail", n, 43);
    chk("clav_occ", 32'(occupancy), 1);
    chk("clav_sent", 32'(cells_sent), 10);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("clav_held_idle", 32'(tx_enb_n), 1);
    end
    tx_clav = 1'b1;
    drain("clav_resume", 53, 1, 0);
    chk("clav_sent2", 32'(cells_sent), 11);
    // Reset at byte 20 with further cells queued.
    tx_clav = 1'b0;
    push(8'hD0, acc);
    push(8'hE0, acc);
    push(8'hF0, acc);
    tx_clav = 1'b1;
    step(21);
    chk("mid_byte20", 32'(tx_data), 32'hE4);
    #2 rst_n = 1'b0;
    sb.delete();
    in_valid = 1'b1;
    in_cell  = mk(8'h11);
    #1;
    chk("mid_rst_enb", 32'(tx_enb_n), 1);
    chk("mid_rst_soc", 32'(tx_soc), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_sent", 32'(cells_sent), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold_enb", 32'(tx_enb_n), 1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step(1);
    chk("mid_rel_occ", 32'(occupancy), 0);
    chk("mid_rel_enb", 32'(tx_enb_n), 1);
    push(8'h5A, acc);
    chk("fresh_acc", 32'(acc), 1);
    drain("fresh", 53, 1, 0);
    chk("fresh_sent", 32'(cells_sent), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
